// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned DATA_W     = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_L = 1'b1
    } owner_t;

    // Request payload as presented by either port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } dmem_req_t;

endpackage

// File: rtl/dmem_rr_picker.sv
// Combinational winner selection between the core and loader ports.
module dmem_rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic   c_req,
    input  logic   l_req,
    input  owner_t last_owner,
    output owner_t winner
);

    // On a tie: core always under fixed priority, else whoever did not go last
    always_comb begin
        winner = OWN_C;
        if (c_req && l_req) begin
            if (FIXED_PRI != 0) begin
                winner = OWN_C;
            end else begin
                winner = (last_owner == OWN_C) ? OWN_L : OWN_C;
            end
        end else if (l_req) begin
            winner = OWN_L;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter/sequencer for the 64-bit data memory: IDLE -> ACCESS -> RESP per transaction.
// Optional build macro DMEM_ALIGN_CHECK_EN also rejects addresses with addr[2:0] != 0.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 64,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic              c_err,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic              l_err,
    output logic [DATA_W-1:0] rdata,
    output logic              core_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MEM_BYTES - WORD_BYTES);

    state_t            state, state_nx;
    owner_t            own, own_nx;
    owner_t            last_owner, last_owner_nx;
    owner_t            winner;
    logic              we_q, we_nx;
    dmem_req_t         sel;
    logic              illegal;

    logic              c_gnt_nx, c_rvalid_nx, c_err_nx;
    logic              l_gnt_nx, l_rvalid_nx, l_err_nx;
    logic [DATA_W-1:0] rdata_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;
    logic              mem_write_nx, mem_read_nx;

    dmem_rr_picker #(
        .FIXED_PRI (FIXED_PRI)
    ) u_picker (
        .c_req      (c_req),
        .l_req      (l_req),
        .last_owner (last_owner),
        .winner     (winner)
    );

    // Winner's payload and its legality
    always_comb begin
        sel.we    = c_we;
        sel.addr  = c_addr;
        sel.wdata = c_wdata;
        if (winner == OWN_L) begin
            sel.we    = l_we;
            sel.addr  = l_addr;
            sel.wdata = l_wdata;
        end
`ifdef DMEM_ALIGN_CHECK_EN
        illegal = (sel.addr > MAX_ADDR) || (sel.addr[2:0] != 3'd0);
`else
        illegal = (sel.addr > MAX_ADDR);
`endif
    end

    // Next state and next registered outputs; mem_* registers double as the latched address/data
    always_comb begin
        state_nx      = state;
        own_nx        = own;
        last_owner_nx = last_owner;
        we_nx         = we_q;
        rdata_nx      = rdata;
        c_gnt_nx      = 1'b0;
        c_rvalid_nx   = 1'b0;
        c_err_nx      = 1'b0;
        l_gnt_nx      = 1'b0;
        l_rvalid_nx   = 1'b0;
        l_err_nx      = 1'b0;
        mem_addr_nx   = '0;
        mem_wdata_nx  = '0;
        mem_write_nx  = 1'b0;
        mem_read_nx   = 1'b0;

        case (state)
            IDLE: begin
                if (c_req || l_req) begin
                    own_nx = winner;
                    we_nx  = sel.we;
                    if (illegal) begin
                        state_nx = RESP;
                        c_gnt_nx = (winner == OWN_C);
                        c_err_nx = (winner == OWN_C);
                        l_gnt_nx = (winner == OWN_L);
                        l_err_nx = (winner == OWN_L);
                    end else begin
                        state_nx     = ACCESS;
                        mem_addr_nx  = sel.addr;
                        mem_wdata_nx = sel.wdata;
                        mem_write_nx = sel.we;
                        mem_read_nx  = ~sel.we;
                    end
                end
            end
            ACCESS: begin
                state_nx    = RESP;
                if (!we_q) begin
                    rdata_nx = mem_rdata;
                end
                c_gnt_nx    = (own == OWN_C);
                c_rvalid_nx = (own == OWN_C) && !we_q;
                l_gnt_nx    = (own == OWN_L);
                l_rvalid_nx = (own == OWN_L) && !we_q;
            end
            RESP: begin
                state_nx      = IDLE;
                last_owner_nx = own;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            own        <= OWN_C;
            last_owner <= OWN_L;
            we_q       <= 1'b0;
            rdata      <= '0;
            c_gnt      <= 1'b0;
            c_rvalid   <= 1'b0;
            c_err      <= 1'b0;
            l_gnt      <= 1'b0;
            l_rvalid   <= 1'b0;
            l_err      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            mem_read   <= 1'b0;
        end else begin
            state      <= state_nx;
            own        <= own_nx;
            last_owner <= last_owner_nx;
            we_q       <= we_nx;
            rdata      <= rdata_nx;
            c_gnt      <= c_gnt_nx;
            c_rvalid   <= c_rvalid_nx;
            c_err      <= c_err_nx;
            l_gnt      <= l_gnt_nx;
            l_rvalid   <= l_rvalid_nx;
            l_err      <= l_err_nx;
            mem_addr   <= mem_addr_nx;
            mem_wdata  <= mem_wdata_nx;
            mem_write  <= mem_write_nx;
            mem_read   <= mem_read_nx;
        end
    end

    assign core_stall = c_req & ~c_gnt;

endmodule
